// File: rtl/rpn_host_link_if.sv
// Host command/result port of the RPN serial link: a valid/ready command channel plus result pulses.
interface rpn_host_link_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [7:0] cmd_data;
   logic       cmd_err;
   logic       res_valid;
   logic [7:0] res_data;
   logic       res_timeout;

   modport master (
      output cmd_valid, cmd_op, cmd_data,
      input  cmd_ready, cmd_err, res_valid, res_data, res_timeout
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data,
      output cmd_ready, cmd_err, res_valid, res_data, res_timeout
   );
endinterface

// File: rtl/rpn_host_link.sv
// Host-side end of the RPN calculator link: serializes commands onto a 1-bit line (MSB first,
// idle low) and deserializes the 8-bit result frames the calculator returns.
module rpn_host_link #(
   parameter int GAP          = 10,
   parameter int RESP_TIMEOUT = 64
) (
   input  logic           clk,
   input  logic           rst,
   rpn_host_link_if.slave host,
   output logic           ser_out,
   input  logic           ser_in
);

   localparam int MAX_COUNT = (GAP > RESP_TIMEOUT) ? ((GAP > 10) ? GAP : 10)
                                                  : ((RESP_TIMEOUT > 10) ? RESP_TIMEOUT : 10);
   localparam int CW = $clog2(MAX_COUNT + 1);
   localparam logic [CW-1:0] ONE        = CW'(1);
   localparam logic [CW-1:0] GAP_LAST   = (GAP > 0) ? CW'(GAP - 1) : '0;
   localparam logic [CW-1:0] TIMEOUT_AT = CW'(RESP_TIMEOUT);
   localparam logic [CW-1:0] PUSH_LAST  = CW'(9);
   localparam logic [CW-1:0] OP_LAST    = CW'(3);

   typedef enum logic [1:0] {IDLE, SEND, GAP_WAIT, WAIT_RES} state_t;

   localparam state_t AFTER_FRAME = (GAP > 0) ? GAP_WAIT : IDLE;

   state_t        state;
   state_t        next_state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;
   logic [9:0]    shreg;
   logic [9:0]    shreg_next;
   logic          ser_next;
   logic          err_next;
   logic          is_enter;
   logic          enter_next;
   logic          cmd_err_q;
   logic          rx_busy;
   logic [2:0]    rx_cnt;
   logic [7:0]    rx_shreg;
   logic          res_valid_q;
   logic [7:0]    res_data_q;
   logic          accept;
   logic          legal;
   logic          timeout_hit;

   assign accept      = host.cmd_valid && (state == IDLE);
   assign legal       = (host.cmd_op == 3'b000) || host.cmd_op[2];
   // A result in progress holds the timeout off; a delivered result beats a simultaneous limit.
   assign timeout_hit = (state == WAIT_RES) && !res_valid_q && !rx_busy && (cnt == TIMEOUT_AT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:     if (accept && legal) next_state = SEND;
         SEND:     if (cnt == '0) next_state = is_enter ? WAIT_RES : AFTER_FRAME;
         GAP_WAIT: if (cnt == '0) next_state = IDLE;
         WAIT_RES: if (res_valid_q || timeout_hit) next_state = AFTER_FRAME;
         default:  next_state = IDLE;
      endcase
   end

   // shreg holds the bits still to send after the start bit, left-aligned; cnt counts them down.
   always_comb begin
      ser_next   = 1'b0;
      shreg_next = shreg;
      cnt_next   = cnt;
      err_next   = 1'b0;
      enter_next = is_enter;
      case (state)
         IDLE: begin
            if (accept) begin
               if (!legal) begin
                  err_next = 1'b1;
               end else begin
                  ser_next   = 1'b1;
                  enter_next = (host.cmd_op == 3'b111);
                  if (host.cmd_op[2]) begin
                     shreg_next = {1'b1, host.cmd_op[1:0], 7'b0};
                     cnt_next   = OP_LAST;
                  end else begin
                     shreg_next = {1'b0, host.cmd_data, 1'b0};
                     cnt_next   = PUSH_LAST;
                  end
               end
            end
         end
         SEND: begin
            if (cnt != '0) begin
               ser_next   = shreg[9];
               shreg_next = {shreg[8:0], 1'b0};
               cnt_next   = cnt - ONE;
            end else begin
               cnt_next = is_enter ? ONE : GAP_LAST;
            end
         end
         GAP_WAIT: begin
            if (cnt != '0) cnt_next = cnt - ONE;
         end
         WAIT_RES: begin
            if (res_valid_q || timeout_hit) cnt_next = GAP_LAST;
            else if (!rx_busy)              cnt_next = cnt + ONE;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ser_out   <= 1'b0;
         shreg     <= '0;
         cnt       <= '0;
         cmd_err_q <= 1'b0;
         is_enter  <= 1'b0;
      end else begin
         ser_out   <= ser_next;
         shreg     <= shreg_next;
         cnt       <= cnt_next;
         cmd_err_q <= err_next;
         is_enter  <= enter_next;
      end
   end

   // Receiver runs regardless of the FSM so results arriving at any time are delivered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_busy     <= 1'b0;
         rx_cnt      <= '0;
         rx_shreg    <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
      end else begin
         res_valid_q <= 1'b0;
         if (!rx_busy) begin
            if (ser_in) begin
               rx_busy <= 1'b1;
               rx_cnt  <= '0;
            end
         end else begin
            rx_shreg <= {rx_shreg[6:0], ser_in};
            rx_cnt   <= rx_cnt + 3'd1;
            if (rx_cnt == 3'd7) begin
               res_data_q  <= {rx_shreg[6:0], ser_in};
               res_valid_q <= 1'b1;
               rx_busy     <= 1'b0;
            end
         end
      end
   end

   assign host.cmd_ready   = (state == IDLE);
   assign host.cmd_err     = cmd_err_q;
   assign host.res_valid   = res_valid_q;
   assign host.res_data    = res_data_q;
   assign host.res_timeout = timeout_hit;

endmodule

// File: tb/tb_rpn_host_link.sv
// Randomized bench for rpn_host_link: a cycle-indexed timeline model predicts every output,
// a stack-based calculator stand-in answers ENTER frames, and literal checks pin the model.
module tb_rpn_host_link;
   localparam int GAP = 10;
   localparam int RT  = 64;
   localparam int N   = 16384;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic ser_out;
   logic ser_in = 1'b0;

   rpn_host_link_if host ();

   rpn_host_link #(.GAP(GAP), .RESP_TIMEOUT(RT)) dut (
      .clk     (clk),
      .rst     (rst),
      .host    (host),
      .ser_out (ser_out),
      .ser_in  (ser_in)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int free_at = 0;
   bit chk_en = 1'b0;

   // Expected value of each output for each clock interval since reset release.
   bit         exp_ser[N];
   bit         exp_rdy[N];
   bit         exp_err[N];
   bit         exp_rv[N];
   bit         exp_to[N];
   logic [7:0] exp_rdata[N];
   logic [7:0] exp_last = 8'h00;

   int          rdy_low, rv_cnt, to_cnt, err_cnt, ones_cnt;
   int          rv_at, to_at, rdy_rise_at, last_one_at;
   logic [7:0]  rv_last;
   logic [63:0] busy_bits;
   bit          prev_rdy = 1'b1;
   logic [7:0]  stack[$];

   always @(posedge clk or negedge rst) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en && rst && cyc < N) begin
         if (exp_rv[cyc]) exp_last = exp_rdata[cyc];
         checkOutput("ser_out",     {31'b0, ser_out},          {31'b0, exp_ser[cyc]});
         checkOutput("cmd_ready",   {31'b0, host.cmd_ready},   {31'b0, exp_rdy[cyc]});
         checkOutput("cmd_err",     {31'b0, host.cmd_err},     {31'b0, exp_err[cyc]});
         checkOutput("res_valid",   {31'b0, host.res_valid},   {31'b0, exp_rv[cyc]});
         checkOutput("res_timeout", {31'b0, host.res_timeout}, {31'b0, exp_to[cyc]});
         checkOutput("res_data",    {24'b0, host.res_data},    {24'b0, exp_last});
         if (!host.cmd_ready) begin
            busy_bits = {busy_bits[62:0], ser_out};
            rdy_low++;
         end else if (!prev_rdy) begin
            rdy_rise_at = cyc;
         end
         prev_rdy = host.cmd_ready;
         if (ser_out) begin ones_cnt++; last_one_at = cyc; end
         if (host.res_valid) begin rv_cnt++; rv_at = cyc; rv_last = host.res_data; end
         if (host.res_timeout) begin to_cnt++; to_at = cyc; end
         if (host.cmd_err) err_cnt++;
      end
   end

   task automatic clearModel();
      for (int i = 0; i < N; i++) begin
         exp_ser[i] = 1'b0; exp_rdy[i] = 1'b1; exp_err[i] = 1'b0;
         exp_rv[i] = 1'b0;  exp_to[i] = 1'b0;  exp_rdata[i] = 8'h00;
      end
      exp_last = 8'h00;
      free_at  = 0;
      prev_rdy = 1'b1;
   endtask

   task automatic clearLog();
      rdy_low = 0; rv_cnt = 0; to_cnt = 0; err_cnt = 0; ones_cnt = 0;
      rv_at = 0; to_at = 0; rdy_rise_at = 0; last_one_at = 0;
      rv_last = 8'h00; busy_bits = '0;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic waitIdle();
      while (cyc <= free_at) nextCycle();
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_ser_out"},   {31'b0, ser_out},          32'd0);
      checkOutput({tag, "_cmd_ready"}, {31'b0, host.cmd_ready},   32'd1);
      checkOutput({tag, "_res_valid"}, {31'b0, host.res_valid},   32'd0);
      checkOutput({tag, "_res_data"},  {24'b0, host.res_data},    32'd0);
      checkOutput({tag, "_timeout"},   {31'b0, host.res_timeout}, 32'd0);
      checkOutput({tag, "_cmd_err"},   {31'b0, host.cmd_err},     32'd0);
   endtask

   // Asynchronous reset asserted mid-interval; outputs must clear without waiting for a clock.
   task automatic doReset();
      chk_en = 1'b0;
      #3 rst = 1'b0;
      #1 checkResetValues("midrst");
      host.cmd_valid = 1'b0;
      ser_in = 1'b0;
      clearModel();
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      nextCycle();
      chk_en = 1'b1;
   endtask

   // Drive one serial result frame starting in interval t.
   task automatic driveFrame(input int t, input logic [7:0] v);
      while (cyc < t) nextCycle();
      ser_in = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         nextCycle();
         ser_in = v[i];
      end
      nextCycle();
      ser_in = 1'b0;
   endtask

   // Offer a command (valid held while busy) and record the outputs it must produce.
   task automatic applyStimulus(input logic [2:0] op, input logic [7:0] data,
                                input bit reply, input int d, input logic [7:0] rval);
      int a;
      int w;
      bit bits[$];
      host.cmd_valid = 1'b1;
      host.cmd_op    = op;
      host.cmd_data  = data;
      a = ((cyc > free_at) ? cyc : free_at) + 1;
      if (!(op == 3'b000 || op >= 3'b100)) begin
         exp_err[a] = 1'b1;
         free_at    = a;
      end else begin
         bits.push_back(1'b1);
         if (op == 3'b000) begin
            bits.push_back(1'b0);
            for (int i = 7; i >= 0; i--) bits.push_back(data[i]);
         end else begin
            bits.push_back(1'b1);
            bits.push_back(op[1]);
            bits.push_back(op[0]);
         end
         for (int i = 0; i < bits.size(); i++) exp_ser[a + i] = bits[i];
         w = a + bits.size();
         if (op != 3'b111) begin
            free_at = w + GAP;
         end else if (reply) begin
            exp_rv[w + d + 9]    = 1'b1;
            exp_rdata[w + d + 9] = rval;
            free_at = w + d + 10 + GAP;
         end else begin
            exp_to[w + RT - 1] = 1'b1;
            free_at = w + RT + GAP;
         end
         for (int i = a; i < free_at; i++) exp_rdy[i] = 1'b0;
      end
      while (cyc < a) nextCycle();
      host.cmd_valid = 1'b0;
      host.cmd_op    = 3'($urandom);
      host.cmd_data  = 8'($urandom);
      if (op == 3'b111 && reply) driveFrame(w + d, rval);
   endtask

   task automatic sendResult(input logic [7:0] v);
      int t;
      waitIdle();
      t = cyc;
      exp_rv[t + 9]    = 1'b1;
      exp_rdata[t + 9] = v;
      driveFrame(t, v);
   endtask

   task automatic rpnCmd(input logic [2:0] op, input logic [7:0] v);
      logic [7:0] x;
      logic [7:0] y;
      logic [7:0] s;
      case (op)
         3'b000: stack.push_back(v);
         3'b100: stack.delete();
         3'b101: begin x = stack.pop_back(); y = stack.pop_back(); s = x + y; stack.push_back(s); end
         3'b110: begin x = stack.pop_back(); y = stack.pop_back(); s = x * y; stack.push_back(s); end
         default: ;
      endcase
      if (op == 3'b111) applyStimulus(op, 8'h00, 1'b1, 5, stack[$]);
      else              applyStimulus(op, v, 1'b0, 0, 8'h00);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int r;
      bit rep;
      int d;
      host.cmd_valid = 1'b0;
      host.cmd_op    = 3'b000;
      host.cmd_data  = 8'h00;
      clearModel();
      clearLog();
      repeat (2) @(posedge clk);
      #1 checkResetValues("reset");
      #2 rst = 1'b1;
      nextCycle();
      chk_en = 1'b1;

      $display("[TB] push 0x05");
      clearLog();
      applyStimulus(3'b000, 8'h05, 1'b0, 0, 8'h00);
      waitIdle();
      checkOutput("push05_bits", busy_bits[31:0], 32'b1000000101_0000000000);
      checkOutput("push05_busy", rdy_low, 32'd20);

      $display("[TB] add then mult, valid held");
      clearLog();
      applyStimulus(3'b101, 8'h00, 1'b0, 0, 8'h00);
      applyStimulus(3'b110, 8'h00, 1'b0, 0, 8'h00);
      waitIdle();
      checkOutput("addmult_bits", busy_bits[31:0], {4'b0, 4'b1101, 10'b0, 4'b1110, 10'b0});
      checkOutput("addmult_busy", rdy_low, 32'd28);

      $display("[TB] enter with reply 0x1B");
      clearLog();
      applyStimulus(3'b111, 8'h00, 1'b1, 5, 8'h1B);
      waitIdle();
      checkOutput("enter_rv_cnt", rv_cnt, 32'd1);
      checkOutput("enter_rv_data", {24'b0, rv_last}, 32'd27);
      checkOutput("enter_ready_rise", rdy_rise_at - rv_at, 32'd11);

      $display("[TB] enter without reply");
      clearLog();
      applyStimulus(3'b111, 8'h00, 1'b0, 0, 8'h00);
      waitIdle();
      checkOutput("timeout_cnt", to_cnt, 32'd1);
      checkOutput("timeout_delay", to_at - last_one_at, 32'd64);
      checkOutput("timeout_ready_rise", rdy_rise_at - to_at, 32'd11);

      $display("[TB] result at the timeout limit");
      clearLog();
      applyStimulus(3'b111, 8'h00, 1'b1, RT - 2, 8'hC3);
      waitIdle();
      checkOutput("late_rv_cnt", rv_cnt, 32'd1);
      checkOutput("late_to_cnt", to_cnt, 32'd0);

      $display("[TB] illegal op and reset mid-push");
      clearLog();
      applyStimulus(3'b010, 8'h00, 1'b0, 0, 8'h00);
      waitIdle();
      checkOutput("illegal_err_cnt", err_cnt, 32'd1);
      checkOutput("illegal_ser_quiet", ones_cnt, 32'd0);
      applyStimulus(3'b000, 8'hFF, 1'b0, 0, 8'h00);
      repeat (3) nextCycle();
      checkOutput("pre_reset_ser", {31'b0, ser_out}, 32'd1);
      doReset();
      clearLog();
      applyStimulus(3'b000, 8'hA5, 1'b0, 0, 8'h00);
      waitIdle();
      checkOutput("post_reset_bits", busy_bits[31:0], 32'b1010100101_0000000000);

      $display("[TB] result outside an enter");
      clearLog();
      sendResult(8'h3C);
      nextCycle();
      checkOutput("unsolicited_rv", {24'b0, rv_last}, 32'h3C);

      $display("[TB] calculator sequence");
      clearLog();
      for (int i = 1; i <= 5; i++) rpnCmd(3'b000, 8'(i));
      rpnCmd(3'b111, 8'h00);
      waitIdle();
      checkOutput("rpn_first", {24'b0, rv_last}, 32'd5);
      rpnCmd(3'b101, 8'h00);
      rpnCmd(3'b111, 8'h00);
      waitIdle();
      checkOutput("rpn_second", {24'b0, rv_last}, 32'd9);
      rpnCmd(3'b000, 8'd254);
      rpnCmd(3'b000, 8'd1);
      rpnCmd(3'b101, 8'h00);
      rpnCmd(3'b111, 8'h00);
      waitIdle();
      checkOutput("rpn_third", {24'b0, rv_last}, 32'd255);

      $display("[TB] random traffic");
      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 9);
         repeat ($urandom_range(0, 2)) nextCycle();
         case (r)
            0, 1, 2: applyStimulus(3'b000, 8'($urandom), 1'b0, 0, 8'h00);
            3:       applyStimulus(3'b100, 8'($urandom), 1'b0, 0, 8'h00);
            4:       applyStimulus(3'b101, 8'($urandom), 1'b0, 0, 8'h00);
            5:       applyStimulus(3'b110, 8'($urandom), 1'b0, 0, 8'h00);
            6, 7: begin
               rep = ($urandom_range(0, 3) != 0);
               d   = $urandom_range(0, RT - 2);
               applyStimulus(3'b111, 8'($urandom), rep, d, 8'($urandom));
            end
            8:       applyStimulus(3'($urandom_range(1, 3)), 8'($urandom), 1'b0, 0, 8'h00);
            default: sendResult(8'($urandom));
         endcase
      end
      waitIdle();
      repeat (3) nextCycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
